pipelined_adder_tile: RTL
=========================

# pipelined_adder_tile

Parametrised, pipelined arithmetic tile for the CGRA datapath: WIDTH-bit add/subtract/accumulate with a valid/ready handshake on both sides, carry chaining between neighbouring tiles, and an on/off gate. It extends the combinational full adder tile with configurable latency, operating modes, a persistent accumulator, signed overflow detection and backpressure. It sits in each tile's ALU slot, between the input crossbar and the output register/router.

## Interface
- WIDTH, 16, operand/result width in bits (>= 2)
- STAGES, 2, pipeline depth, and therefore latency in cycles (1..4)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- on_off  in  1  tile enable; 0 freezes the tile and blanks the outputs
- carry_listen  in  1  1: use carry_in; 0: use the default carry for the mode
- mode  in  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD
- in_valid  in  1  operand transaction offered
- in_ready  out  1  tile accepts this cycle
- a, b  in  WIDTH  operands (b ignored in ACC and LOAD)
- carry_in  in  1  chained carry (SUB: 1 = no borrow)
- ack  out  1  one-cycle pulse per accepted transaction
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- c  out  WIDTH  result
- carry_out  out  1  carry out of the MSB
- overflow  out  1  signed two's-complement overflow of this result

## Operation
- Accept = in_valid & in_ready. The result is computed at accept time into stage 1; stages 2..STAGES delay it.
- cin_eff = carry_listen ? carry_in : (mode==SUB ? 1 : 0).
- ADD: {carry_out,c} = a + b + cin_eff.
- SUB: {carry_out,c} = a + ~b + cin_eff. carry_out=1 means no borrow.
- ACC: {carry_out,c} = acc + a + cin_eff; acc <= c on accept.
- LOAD: c = a, carry_out = 0, overflow = 0; acc <= a on accept.
- overflow (ADD/SUB/ACC): the two addend MSBs are equal and the result MSB differs.
- Each pipeline stage holds {valid, c, carry_out, overflow}.
- advance = on_off & (~out_valid_int | out_ready). On advance every stage shifts by one. Stage 1 loads the accepted result, or valid=0 if nothing was accepted.
- in_ready = advance. ack = accept, not registered.
- on_off=0:
  - in_ready=0, ack=0.
  - out_valid, c, carry_out and overflow read 0.
  - Pipeline contents and acc are retained, not flushed.
  - Draining resumes when on_off returns to 1.
- Results leave in acceptance order with no loss or duplication. A result is held stable while out_valid & ~out_ready.

## Timing
- Reset (asynchronous): all stage valid bits=0 and data=0, acc=0. Outputs in_ready=0 (only if on_off=0, otherwise per advance), ack=0, out_valid=0, c=0, carry_out=0, overflow=0.
- Reset mid-operation: in-flight results are discarded, acc=0, no partial output.
- Latency: a result accepted at edge N is visible on out_valid/c at edge N+STAGES-1 (the stage 1 register is output when STAGES=1). Full throughput is 1 result per cycle with out_ready held high.
- Back-to-back ACC: each accept sees the acc updated by the previous accept (no hazard, since the update happens in stage 1).
- Simultaneous accept at input and output under a full pipeline is allowed: advance=1, no bubble.
- out_ready low while the last stage is valid stalls the whole pipeline and drops in_ready in the same cycle.
- Toggling on_off takes effect combinationally on in_ready and the outputs. The state update follows on the next edge.

## Configuration
- PIPE_ADDER_SAT_EN defined: on overflow in ADD/SUB/ACC, c saturates to 0x7FF..F (positive overflow) or 0x800..0 (negative overflow). overflow is still 1, carry_out is the raw carry, and the ACC accumulator stores the saturated value.
- PIPE_ADDER_SAT_EN undefined: two's-complement wrap; c and acc are the raw sum.

## Test plan
All scenarios use WIDTH=16, STAGES=2.
- Reset: assert reset mid-stream with 2 results in flight -> immediately out_valid=0, c=0, carry_out=0, ack=0; after release, the next ACC a=0x0001 gives c=0x0001 (acc was cleared).
- ADD a=0x1234, b=0x5678, carry_listen=1, carry_in=1 -> ack pulse at accept, out_valid 1 cycle later, c=0x68AD, carry_out=0; same with carry_listen=0 -> c=0x68AC; a=0xFFFF, b=0x0001 -> c=0x0000, carry_out=1, overflow=0.
- SUB a=0x0005, b=0x0007, carry_listen=0 -> c=0xFFFE, carry_out=0; a=0x8000, b=0x0001 -> c=0x7FFF, overflow=1 (with SAT: c=0x8000).
- LOAD a=0x7000, then ACC a=0x1000, then ACC a=0x0001 -> c=0x7000, 0x8000 (overflow=1), 0x8001; with PIPE_ADDER_SAT_EN -> 0x7000, 0x7FFF (overflow=1), 0x7FFF (overflow=1).
- Backpressure: 5 back-to-back ADDs (a=1..5, b=0), out_ready low for 4 cycles mid-stream -> in_ready drops while the last stage is full, c is held stable, outputs are 1,2,3,4,5 in order with none lost or duplicated.
- on_off=0 with 1 result in flight -> out_valid=0, c=0, in_ready=0, ack=0 despite in_valid=1; on_off=1 -> the held result appears intact and acc is unchanged.

Source files
------------

// File: rtl/pipelined_adder_tile.sv
// Pipelined WIDTH-bit add/sub/accumulate tile with valid/ready handshake and on/off gate.
// Define PIPE_ADDER_SAT_EN to saturate results on signed overflow instead of wrapping.
module pipelined_adder_tile #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             on_off,
    input  logic             carry_listen,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             carry_out,
    output logic             overflow
);

    localparam logic [1:0] MODE_ADD  = 2'b00;
    localparam logic [1:0] MODE_SUB  = 2'b01;
    localparam logic [1:0] MODE_ACC  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] acc_q, acc_d;

    logic             stage_valid_q [STAGES];
    logic [WIDTH-1:0] stage_c_q     [STAGES];
    logic             stage_carry_q [STAGES];
    logic             stage_ovf_q   [STAGES];

    logic             out_valid_int;
    logic             advance;
    logic             accept;
    logic             cin_eff;
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res_c;
    logic             res_carry;
    logic             res_ovf;

    // The whole pipeline moves as one; a stalled tail stalls every stage.
    assign out_valid_int = stage_valid_q[STAGES-1];
    assign advance       = on_off & (~out_valid_int | out_ready);
    assign in_ready      = advance;
    assign accept        = in_valid & advance;
    assign ack           = accept;

    always_comb begin
        cin_eff = carry_listen ? carry_in : (mode == MODE_SUB);
        op_x    = a;
        op_y    = '0;
        case (mode)
            MODE_ADD: begin
                op_x = a;
                op_y = b;
            end
            MODE_SUB: begin
                op_x = a;
                op_y = ~b;
            end
            MODE_ACC: begin
                op_x = acc_q;
                op_y = a;
            end
            default: begin
                op_x = a;
                op_y = '0;
            end
        endcase

        sum       = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, cin_eff};
        res_c     = sum[WIDTH-1:0];
        res_carry = sum[WIDTH];
        res_ovf   = (op_x[WIDTH-1] == op_y[WIDTH-1]) && (sum[WIDTH-1] != op_x[WIDTH-1]);

`ifdef PIPE_ADDER_SAT_EN
        // Both addends share a sign on overflow, so op_x's MSB gives the direction.
        if (res_ovf) begin
            res_c = op_x[WIDTH-1] ? SAT_NEG : SAT_POS;
        end
`endif

        if (mode == MODE_LOAD) begin
            res_c     = a;
            res_carry = 1'b0;
            res_ovf   = 1'b0;
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (accept && (mode == MODE_ACC || mode == MODE_LOAD)) begin
            acc_d = res_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                stage_valid_q[i] <= 1'b0;
                stage_c_q[i]     <= '0;
                stage_carry_q[i] <= 1'b0;
                stage_ovf_q[i]   <= 1'b0;
            end
        end else begin
            acc_q <= acc_d;
            if (advance) begin
                stage_valid_q[0] <= accept;
                stage_c_q[0]     <= accept ? res_c : '0;
                stage_carry_q[0] <= accept & res_carry;
                stage_ovf_q[0]   <= accept & res_ovf;
                for (int i = 1; i < STAGES; i++) begin
                    stage_valid_q[i] <= stage_valid_q[i-1];
                    stage_c_q[i]     <= stage_c_q[i-1];
                    stage_carry_q[i] <= stage_carry_q[i-1];
                    stage_ovf_q[i]   <= stage_ovf_q[i-1];
                end
            end
        end
    end

    // Outputs are blanked while the tile is off; state underneath is retained.
    assign out_valid = on_off & out_valid_int;
    assign c         = on_off ? stage_c_q[STAGES-1] : '0;
    assign carry_out = on_off & stage_carry_q[STAGES-1];
    assign overflow  = on_off & stage_ovf_q[STAGES-1];

endmodule
